// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and default parameters for serial_frame_tx
package serial_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t SHIFT = 2'd2;
    localparam state_t STOP  = 2'd3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_HALF_DIV = 4;
    localparam int DEF_MSB_FIRST = 1;
    localparam logic [7:0] DEF_BTN_PATTERN = 8'hA5;
endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// bit_timer: HALF_DIV clk divider producing half-period and bit-period strobes
module bit_timer #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic half_tick,
    output logic bit_end
);
    localparam int CW = $clog2(HALF_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);
    logic [CW-1:0] cnt;
    logic phase;
    assign half_tick = run && cnt == LAST;
    assign bit_end = half_tick && phase;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            phase <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            phase <= 1'b0;
        end else if (half_tick) begin
            cnt <= '0;
            phase <= !phase;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start/data/stop framed serial transmitter with sck, triggered by handshake or button
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int HALF_DIV = DEF_HALF_DIV,
    parameter int MSB_FIRST = DEF_MSB_FIRST,
    parameter logic [DATA_W-1:0] BTN_PATTERN = DATA_W'(DEF_BTN_PATTERN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bbutton,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              sda,
    output logic              sck
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    state_t state;
    logic [DATA_W-1:0] sr;
    logic [BW-1:0] bit_cnt;
    logic [2:0] btn;
    logic fall, accept, half_tick, bit_end, cur;
    // btn[1] is the synchronised button, btn[2] its previous value
    assign fall = btn[2] && !btn[1];
    assign tx_ready = state == IDLE;
    assign busy = !tx_ready;
    assign accept = tx_ready && (tx_valid || fall);
    assign cur = MSB_FIRST != 0 ? sr[DATA_W-1] : sr[0];
    assign sda = state == START ? 1'b0 : state == SHIFT ? cur : 1'b1;
    bit_timer #(.HALF_DIV(HALF_DIV)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .clear(accept),
        .run(busy),
        .half_tick(half_tick),
        .bit_end(bit_end)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr <= '0;
            bit_cnt <= '0;
            btn <= '1;
            sck <= 1'b0;
        end else begin
            btn <= {btn[1:0], bbutton};
            sck <= state == SHIFT && (half_tick ? !sck : sck);
            if (accept) begin
                sr <= tx_valid ? tx_data : BTN_PATTERN;
                state <= START;
                bit_cnt <= '0;
            end else if (bit_end) begin
                state <= state == START ? SHIFT : state == STOP ? IDLE : bit_cnt == LAST_BIT ? STOP : SHIFT;
                if (state == SHIFT) begin
                    sr <= MSB_FIRST != 0 ? sr << 1 : sr >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: randomized checks of three serial_frame_tx configurations against a waveform model
module tb_serial_frame_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bbutton [3];
    logic tx_valid [3];
    logic [7:0] tx_data [3];
    logic tx_ready [3];
    logic busy [3];
    logic sda [3];
    logic sck [3];
    int checks = 0;
    int errors = 0;
    int dw [3] = '{8, 8, 4};
    int hw [3] = '{4, 4, 1};
    int mf [3] = '{1, 0, 1};
    logic act_sda [1:256];
    logic act_sck [1:256];
    logic act_rdy [1:256];

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .HALF_DIV(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .bbutton(bbutton[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .busy(busy[0]), .sda(sda[0]), .sck(sck[0]));
    serial_frame_tx #(.DATA_W(8), .HALF_DIV(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bbutton(bbutton[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .busy(busy[1]), .sda(sda[1]), .sck(sck[1]));
    serial_frame_tx #(.DATA_W(4), .HALF_DIV(1), .MSB_FIRST(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .bbutton(bbutton[2]), .tx_data(tx_data[2][3:0]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .busy(busy[2]), .sda(sda[2]), .sck(sck[2]));

    // expected {tx_ready, sda, sck} in cycle c after an accept at edge 0 (cycle c lies between edges c-1 and c)
    function automatic logic [2:0] model(int d, logic [7:0] w, int c);
        int tp, p, ph;
        logic b;
        tp = 2 * hw[d];
        p = (c - 1) / tp;
        ph = (c - 1) % tp;
        if (p == 0) return 3'b000;
        if (p <= dw[d]) begin
            b = mf[d] != 0 ? w[dw[d] - p] : w[p - 1];
            return {1'b0, b, logic'(ph >= hw[d])};
        end
        if (p == dw[d] + 1) return 3'b010;
        return 3'b110;
    endfunction

    function automatic int frame_len(int d);
        return (dw[d] + 2) * 2 * hw[d] + 1;
    endfunction

    task automatic send(int d, logic [7:0] w);
        @(negedge clk);
        tx_data[d] = w;
        tx_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        tx_valid[d] = 1'b0;
        tx_data[d] = 8'($urandom);
    endtask

    task automatic capture(int d, int n);
        for (int c = 1; c <= n; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            act_sda[c] = sda[d];
            act_sck[c] = sck[d];
            act_rdy[c] = tx_ready[d];
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            bbutton[d] = 1'b1;
            tx_valid[d] = 1'b0;
            tx_data[d] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({tx_ready[d], busy[d], sda[d], sck[d]} !== 4'b1010) begin
                errors++;
                $display("FAIL reset d=%0d got rdy/busy/sda/sck=%b want 1010", d, {tx_ready[d], busy[d], sda[d], sck[d]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_frames(int d, logic [7:0] first, string name);
        logic [7:0] w;
        logic [2:0] e;
        for (int k = 0; k < 3; k++) begin
            w = k == 0 ? first : 8'($urandom);
            if (dw[d] == 4) w[7:4] = 4'h0;
            send(d, w);
            checks++;
            if (busy[d] !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy word=%h got %b want 1", name, w, busy[d]);
            end
            capture(d, frame_len(d));
            for (int c = 1; c <= frame_len(d); c++) begin
                e = model(d, w, c);
                checks++;
                if ({act_rdy[c], act_sda[c], act_sck[c]} !== e) begin
                    errors++;
                    $display("FAIL %s word=%h cycle=%0d got rdy/sda/sck=%b want %b", name, w, c,
                             {act_rdy[c], act_sda[c], act_sck[c]}, e);
                end
            end
        end
    endtask

    task automatic test_button();
        int k;
        logic [2:0] e;
        @(negedge clk);
        bbutton[0] = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (tx_ready[0] && k < 10);
        checks++;
        if (tx_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL button_start got tx_ready=%b want 0 within 10 cycles", tx_ready[0]);
        end
        fork
            capture(0, frame_len(0));
            begin
                repeat (20) @(negedge clk);
                bbutton[0] = 1'b1;
                repeat (10) @(negedge clk);
                bbutton[0] = 1'b0;
                repeat (10) @(negedge clk);
                bbutton[0] = 1'b1;
            end
        join
        for (int c = 1; c <= frame_len(0); c++) begin
            e = model(0, 8'hA5, c);
            checks++;
            if ({act_rdy[c], act_sda[c], act_sck[c]} !== e) begin
                errors++;
                $display("FAIL button_frame cycle=%0d got rdy/sda/sck=%b want %b", c, {act_rdy[c], act_sda[c], act_sck[c]}, e);
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tx_ready[0] !== 1'b1 || sda[0] !== 1'b1) begin
                errors++;
                $display("FAIL button_busy_ignored cycle=%0d got rdy/sda=%b%b want 11", c, tx_ready[0], sda[0]);
            end
        end
    endtask

    task automatic test_button_tie();
        logic [2:0] e;
        @(negedge clk);
        bbutton[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_data[0] = 8'h3C;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        capture(0, frame_len(0));
        for (int c = 1; c <= frame_len(0); c++) begin
            e = model(0, 8'h3C, c);
            checks++;
            if ({act_rdy[c], act_sda[c], act_sck[c]} !== e) begin
                errors++;
                $display("FAIL tie_frame cycle=%0d got rdy/sda/sck=%b want %b", c, {act_rdy[c], act_sda[c], act_sck[c]}, e);
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tx_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL tie_single_frame cycle=%0d got tx_ready=%b want 1", c, tx_ready[0]);
            end
        end
        @(negedge clk);
        bbutton[0] = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [2:0] e;
        n = frame_len(0);
        @(negedge clk);
        tx_data[0] = 8'h55;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_data[0] = 8'hAA;
        fork
            capture(0, 2 * n);
            begin
                repeat (n) @(posedge clk);
                #2;
                tx_valid[0] = 1'b0;
            end
        join
        for (int c = 1; c <= 2 * n; c++) begin
            e = c <= n ? model(0, 8'h55, c) : model(0, 8'hAA, c - n);
            checks++;
            if ({act_rdy[c], act_sda[c], act_sck[c]} !== e) begin
                errors++;
                $display("FAIL back_to_back cycle=%0d got rdy/sda/sck=%b want %b", c, {act_rdy[c], act_sda[c], act_sck[c]}, e);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (tx_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_end got tx_ready=%b want 1", tx_ready[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        logic [2:0] e;
        w = 8'($urandom);
        send(0, w);
        capture(0, 36);
        for (int c = 1; c <= 36; c++) begin
            e = model(0, w, c);
            checks++;
            if ({act_rdy[c], act_sda[c], act_sck[c]} !== e) begin
                errors++;
                $display("FAIL pre_reset word=%h cycle=%0d got rdy/sda/sck=%b want %b", w, c, {act_rdy[c], act_sda[c], act_sck[c]}, e);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_ready[0], busy[0], sda[0], sck[0]} !== 4'b1010) begin
            errors++;
            $display("FAIL mid_reset got rdy/busy/sda/sck=%b want 1010", {tx_ready[0], busy[0], sda[0], sck[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({tx_ready[0], sda[0], sck[0]} !== 3'b110) begin
                errors++;
                $display("FAIL post_reset_idle cycle=%0d got rdy/sda/sck=%b want 110", c, {tx_ready[0], sda[0], sck[0]});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_frames(0, 8'hC3, "msb");
        test_frames(1, 8'h01, "lsb");
        test_frames(2, 8'h0A, "fast");
        test_button();
        test_button_tie();
        test_back_to_back();
        test_reset_mid();
        test_frames(0, 8'h96, "msb_after_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
